// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module      : multicycle_controller_if
// Description : Control/status bundle between the multicycle controller and
//               its datapath plus the shared memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
  logic [5:0] op;
  logic       zero;
  logic       alu_neg;
  logic       mem_ready;

  logic       mem_req;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       illegal;

  modport master (
    input  op, zero, alu_neg, mem_ready,
    output mem_req, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, aluop,
           memwrite, regwrite, regdst, memtoreg, illegal
  );

  modport slave (
    output op, zero, alu_neg, mem_ready,
    input  mem_req, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, aluop,
           memwrite, regwrite, regdst, memtoreg, illegal
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM of the multicycle MIPS core, sequencing fetch,
//               decode, execute, memory and writeback over one shared memory
//               port with a req/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter logic [5:0] OP_BGE    = 6'b010010,
  parameter logic [5:0] OP_SWAPRM = 6'b010011
) (
  input  wire logic               clk,
  input  wire logic               reset,
  multicycle_controller_if.master io_bus
);

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_SWAPWR = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BEQ    = 4'd11,
    S_BGE    = 4'd12,
    S_JUMP   = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       r_mem_req;
  logic       r_iord;
  logic [1:0] r_pcsrc;
  logic       r_alusrca;
  logic [1:0] r_alusrcb;
  logic [1:0] r_aluop;
  logic       r_memwrite;
  logic       r_regwrite;
  logic       r_regdst;
  logic       r_memtoreg;
  logic       r_illegal;
  // One-hot state qualifiers for the input-gated strobes pcen/irwrite
  logic       r_in_fetch;
  logic       r_in_beq;
  logic       r_in_bge;
  logic       r_in_jump;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (io_bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (io_bus.op == C_OP_LW || io_bus.op == C_OP_SW || io_bus.op == OP_SWAPRM)
          w_next = S_MEMADR;
        else if (io_bus.op == C_OP_RTYPE) w_next = S_EXEC;
        else if (io_bus.op == C_OP_ADDI)  w_next = S_ADDIEX;
        else if (io_bus.op == C_OP_BEQ)   w_next = S_BEQ;
        else if (io_bus.op == OP_BGE)     w_next = S_BGE;
        else if (io_bus.op == C_OP_J)     w_next = S_JUMP;
        else                              w_next = S_TRAP;
      end
      S_MEMADR: w_next = (io_bus.op == C_OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (io_bus.mem_ready)
          w_next = (io_bus.op == OP_SWAPRM) ? S_SWAPWR : S_MEMWB;
      end
      S_SWAPWR: if (io_bus.mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (io_bus.mem_ready) w_next = S_FETCH;
      S_MEMWB:  w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_BEQ:    w_next = S_FETCH;
      S_BGE:    w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Outputs are registered against the next state, so they are Moore values
  // of the current state; the reset image is the FETCH output set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_mem_req  <= 1'b1;
      r_iord     <= 1'b0;
      r_pcsrc    <= 2'b00;
      r_alusrca  <= 1'b0;
      r_alusrcb  <= 2'b01;
      r_aluop    <= 2'b00;
      r_memwrite <= 1'b0;
      r_regwrite <= 1'b0;
      r_regdst   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_illegal  <= 1'b0;
      r_in_fetch <= 1'b1;
      r_in_beq   <= 1'b0;
      r_in_bge   <= 1'b0;
      r_in_jump  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_mem_req  <= 1'b0;
      r_iord     <= 1'b0;
      r_pcsrc    <= 2'b00;
      r_alusrca  <= 1'b0;
      r_alusrcb  <= 2'b00;
      r_aluop    <= 2'b00;
      r_memwrite <= 1'b0;
      r_regwrite <= 1'b0;
      r_regdst   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_illegal  <= 1'b0;
      r_in_fetch <= 1'b0;
      r_in_beq   <= 1'b0;
      r_in_bge   <= 1'b0;
      r_in_jump  <= 1'b0;
      case (w_next)
        S_FETCH: begin
          r_mem_req  <= 1'b1;
          r_alusrcb  <= 2'b01;
          r_in_fetch <= 1'b1;
        end
        S_DECODE: r_alusrcb <= 2'b11;
        S_MEMADR: begin
          r_alusrca <= 1'b1;
          r_alusrcb <= 2'b10;
        end
        S_MEMRD: begin
          r_mem_req <= 1'b1;
          r_iord    <= 1'b1;
        end
        S_SWAPWR, S_MEMWR: begin
          r_mem_req  <= 1'b1;
          r_iord     <= 1'b1;
          r_memwrite <= 1'b1;
        end
        S_MEMWB: begin
          r_regwrite <= 1'b1;
          r_memtoreg <= 1'b1;
        end
        S_EXEC: begin
          r_alusrca <= 1'b1;
          r_aluop   <= 2'b10;
        end
        S_ALUWB: begin
          r_regwrite <= 1'b1;
          r_regdst   <= 1'b1;
        end
        S_ADDIEX: begin
          r_alusrca <= 1'b1;
          r_alusrcb <= 2'b10;
        end
        S_ADDIWB: r_regwrite <= 1'b1;
        S_BEQ, S_BGE: begin
          r_alusrca <= 1'b1;
          r_aluop   <= 2'b01;
          r_pcsrc   <= 2'b01;
          r_in_beq  <= (w_next == S_BEQ);
          r_in_bge  <= (w_next == S_BGE);
        end
        S_JUMP: begin
          r_pcsrc   <= 2'b10;
          r_in_jump <= 1'b1;
        end
        S_TRAP:  r_illegal <= 1'b1;
        default: r_illegal <= 1'b0;
      endcase
    end
  end

  // Strobes are masked by reset combinationally so they fall the moment
  // reset rises, independent of the clock.
  assign io_bus.mem_req  = r_mem_req & ~reset;
  assign io_bus.irwrite  = r_in_fetch & io_bus.mem_ready & ~reset;
  assign io_bus.pcen     = ~reset & ((r_in_fetch & io_bus.mem_ready) |
                                     (r_in_beq   & io_bus.zero)      |
                                     (r_in_bge   & ~io_bus.alu_neg)  |
                                      r_in_jump);
  assign io_bus.memwrite = r_memwrite & ~reset;
  assign io_bus.regwrite = r_regwrite & ~reset;
  assign io_bus.illegal  = r_illegal & ~reset;
  assign io_bus.iord     = r_iord;
  assign io_bus.pcsrc    = r_pcsrc;
  assign io_bus.alusrca  = r_alusrca;
  assign io_bus.alusrcb  = r_alusrcb;
  assign io_bus.aluop    = r_aluop;
  assign io_bus.regdst   = r_regdst;
  assign io_bus.memtoreg = r_memtoreg;

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several clocks per instruction, using one shared memory port for instructions and data.
- Supports the same opcode set as the single-cycle core: R-type, LW, SW, BEQ, ADDI, J, BGE, SwapRM.
- Memory accesses use a req/ready handshake, so wait states are tolerated.

Parameters:
- OP_BGE, 6'b010010, opcode of branch-if-greater-or-equal.
- OP_SWAPRM, 6'b010011, opcode of SwapRM (read mem[rs+imm] into rt, write old rt to the same address).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns FSM to FETCH.
- op  in  6  opcode from instruction register, valid from DECODE onward.
- zero  in  1  ALU result == 0 (A-B).
- alu_neg  in  1  sign bit of A-B.
- mem_ready  in  1  memory completes the current req this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- irwrite  out  1  load instruction register.
- pcen  out  1  PC write enable.
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alusrca  out  1  0 = PC, 1 = reg A.
- alusrcb  out  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2.
- aluop  out  2  00 add, 01 sub, 10 use funct.
- memwrite  out  1  write strobe, qualified by mem_req.
- regwrite  out  1  register file write.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = data register, 0 = ALUOut.
- illegal  out  1  sticky illegal-opcode flag.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, SWAPWR, EXEC, ALUWB, ADDIEX, ADDIWB, BEQ, BGE, JUMP, TRAP. Outputs are Moore, except that pcen and irwrite are also gated by inputs.
- Every signal not listed for a state is 0.
- Reset: state = FETCH asynchronously. While reset is high, mem_req, irwrite, pcen, memwrite, regwrite and illegal are forced to 0. The mux selects take FETCH values: alusrca 0, alusrcb 01, aluop 00, pcsrc 00, iord 0.
- FETCH:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Stay in FETCH while mem_ready=0, otherwise go to DECODE.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state by op: LW/SW/SwapRM -> MEMADR; 000000 -> EXEC; ADDI 001000 -> ADDIEX; BEQ 000100 -> BEQ; BGE -> BGE; J 000010 -> JUMP; any other -> TRAP.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW/SwapRM -> MEMRD; SW -> MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready. On ready, LW -> MEMWB and SwapRM -> SWAPWR.
- SWAPWR: mem_req=1, iord=1, memwrite=1 (old rt on B). Hold until mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, then -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Hold until mem_ready, then -> FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10, then -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, then -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00, then -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, then -> FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero, then -> FETCH.
- BGE: same mux settings as BEQ, pcen=~alu_neg (A >= B signed), then -> FETCH.
- JUMP: pcsrc=10, pcen=1, then -> FETCH.
- TRAP: illegal=1, all strobes 0. Stays in TRAP until reset.
- Strobe rules:
  - memwrite is never asserted outside MEMWR and SWAPWR.
  - regwrite is never asserted in the same cycle as mem_req.
- Cycle counts with zero-wait memory (mem_ready tied 1):
  - LW 5, SwapRM 6, SW 4, R-type 4, ADDI 4, BEQ/BGE/J 3.
  - Each wait cycle adds one cycle in the waiting state.
- Reset asserted mid-instruction (e.g. in SWAPWR): memwrite drops immediately (asynchronous), and the first cycle after reset release is FETCH.

Test Plan:
- mem_ready=1, op=100011 (LW) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 with memtoreg=1 only in cycle 5.
- op=010011 (SwapRM), mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles, then SWAPWR with memwrite=1 and iord=1, then MEMWB; total 8 cycles.
- op=010010 (BGE) in BGE state:
  - zero=1, alu_neg=0 -> pcen=1, pcsrc=01.
  - alu_neg=1 -> pcen=0.
- op=000100 (BEQ) with zero=0 -> pcen=0 in BEQ state. Next FETCH with mem_ready=0 for 3 cycles -> irwrite=pcen=0 until ready.
- op=111111 in DECODE -> TRAP, illegal=1 held for 20 cycles. Reset pulse -> illegal=0, state FETCH.
- Reset asserted asynchronously in SWAPWR between clock edges -> memwrite and mem_req go 0 the same cycle; after release, FETCH outputs alusrcb=01 and mem_req=1.
